// File: rtl/hsv_bbox_detect_if.sv
// Result bus of the HSV bounding-box detector: per-frame bounding box,
// match count and the valid/ack/overflow handshake towards the consumer.
interface hsv_bbox_detect_if;
  logic [10:0] x_min;
  logic [10:0] x_max;
  logic [10:0] y_min;
  logic [10:0] y_max;
  logic [19:0] pix_cnt;
  logic        found;
  logic        result_valid;
  logic        result_ack;
  logic        result_ovf;

  // Detector side: publishes results, samples the acknowledge
  modport master (
    output x_min, x_max, y_min, y_max, pix_cnt, found, result_valid, result_ovf,
    input  result_ack
  );

  // Consumer side: reads results, returns the acknowledge
  modport slave (
    input  x_min, x_max, y_min, y_max, pix_cnt, found, result_valid, result_ovf,
    output result_ack
  );
endinterface

// File: rtl/hsv_bbox_detect.sv
// HSV colour-range detector: produces a binary mask stream (2-cycle latency)
// and, once per frame, the bounding box and pixel count of all matches.
// The first partial frame after reset is discarded; results are published
// on the vsync rising edge that ends each complete frame.
module hsv_bbox_detect #(
  parameter logic [7:0] H_MIN = 8'd21,
  parameter logic [7:0] H_MAX = 8'd32,
  parameter logic [7:0] S_MIN = 8'd40,
  parameter logic [7:0] V_MIN = 8'd50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsv_vsync,
  input  logic        hsv_hsync,
  input  logic        hsv_de,
  input  logic [23:0] hsv_data,
  output logic        mask_vsync,
  output logic        mask_hsync,
  output logic        mask_de,
  output logic [23:0] mask_data,
  hsv_bbox_detect_if.master res
);

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  localparam logic [10:0] COORD_MAX = 11'd2047;
  localparam logic [19:0] CNT_MAX   = 20'hFFFFF;

  logic [7:0]  hue, sat, val;
  logic        hue_ok, pix_hit;
  logic        vs_prev, de_prev, vs_rise, de_fall;
  logic [10:0] x_next, y_cnt, cur_x, cur_y;
  logic        s1_vs, s1_hs, s1_de, s1_hit;
  logic [1:0]  state, state_nx;
  logic        pend_hit;
  logic [10:0] pend_x, pend_y;
  logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [19:0] acc_cnt;
  logic [10:0] nx_xmin, nx_xmax, nx_ymin, nx_ymax;
  logic [19:0] nx_cnt;
  logic        take_cur;

  assign val = hsv_data[23:16];
  assign sat = hsv_data[15:8];
  assign hue = hsv_data[7:0];

  // Hue window, wrapping through 255/0 when the bounds are given reversed
  always_comb begin
    if (H_MIN <= H_MAX) hue_ok = (hue >= H_MIN) && (hue <= H_MAX);
    else                hue_ok = (hue >= H_MIN) || (hue <= H_MAX);
  end

  assign pix_hit = hsv_de && hue_ok && (sat >= S_MIN) && (val >= V_MIN);
  assign vs_rise = hsv_vsync && !vs_prev;
  assign de_fall = de_prev && !hsv_de;
  // The first active pixel of a line is column 0; a pixel during the vsync
  // rising edge already belongs to row 0 of the new frame.
  assign cur_x   = de_prev ? x_next : 11'd0;
  assign cur_y   = vs_rise ? 11'd0 : y_cnt;

  // Two-stage mask pipeline with timing delayed alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vs <= 1'b0; s1_hs <= 1'b0; s1_de <= 1'b0; s1_hit <= 1'b0;
      mask_vsync <= 1'b0; mask_hsync <= 1'b0; mask_de <= 1'b0;
      mask_data  <= 24'h000000;
    end else begin
      s1_vs <= hsv_vsync; s1_hs <= hsv_hsync; s1_de <= hsv_de; s1_hit <= pix_hit;
      mask_vsync <= s1_vs; mask_hsync <= s1_hs; mask_de <= s1_de;
      mask_data  <= (s1_de && s1_hit) ? 24'hFFFFFF : 24'h000000;
    end
  end

  // Edge detectors and saturating pixel coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev <= 1'b0; de_prev <= 1'b0;
      x_next  <= 11'd0; y_cnt <= 11'd0;
    end else begin
      vs_prev <= hsv_vsync;
      de_prev <= hsv_de;
      if (hsv_de) x_next <= (cur_x == COORD_MAX) ? COORD_MAX : cur_x + 11'd1;
      if (vs_rise)                            y_cnt <= 11'd0;
      else if (de_fall && y_cnt != COORD_MAX) y_cnt <= y_cnt + 11'd1;
    end
  end

  // Frame state: wait for a full frame, accumulate, publish for one cycle
  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT:    if (vs_rise) state_nx = ST_ACCUM;
      ST_ACCUM:   if (vs_rise) state_nx = ST_PUBLISH;
      ST_PUBLISH: state_nx = ST_ACCUM;
      default:    state_nx = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nx;
  end

  // A match on the frame-ending vsync edge is parked until the accumulators
  // have been handed over, so it lands in the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_hit <= 1'b0; pend_x <= 11'd0; pend_y <= 11'd0;
    end else if (state == ST_ACCUM && vs_rise) begin
      pend_hit <= pix_hit; pend_x <= cur_x; pend_y <= cur_y;
    end else begin
      pend_hit <= 1'b0;
    end
  end

  // Next accumulator values: restart on publish, fold in parked and current hits
  always_comb begin
    nx_xmin = acc_xmin; nx_xmax = acc_xmax;
    nx_ymin = acc_ymin; nx_ymax = acc_ymax;
    nx_cnt  = acc_cnt;
    if (state == ST_PUBLISH) begin
      nx_xmin = COORD_MAX; nx_xmax = 11'd0;
      nx_ymin = COORD_MAX; nx_ymax = 11'd0;
      nx_cnt  = 20'd0;
      if (pend_hit) begin
        nx_xmin = pend_x; nx_xmax = pend_x;
        nx_ymin = pend_y; nx_ymax = pend_y;
        nx_cnt  = 20'd1;
      end
    end
    take_cur = pix_hit && ((state == ST_ACCUM && !vs_rise) || state == ST_PUBLISH);
    if (take_cur) begin
      if (cur_x < nx_xmin) nx_xmin = cur_x;
      if (cur_x > nx_xmax) nx_xmax = cur_x;
      if (cur_y < nx_ymin) nx_ymin = cur_y;
      if (cur_y > nx_ymax) nx_ymax = cur_y;
      if (nx_cnt != CNT_MAX) nx_cnt = nx_cnt + 20'd1;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_xmin <= COORD_MAX; acc_xmax <= 11'd0;
      acc_ymin <= COORD_MAX; acc_ymax <= 11'd0;
      acc_cnt  <= 20'd0;
    end else begin
      acc_xmin <= nx_xmin; acc_xmax <= nx_xmax;
      acc_ymin <= nx_ymin; acc_ymax <= nx_ymax;
      acc_cnt  <= nx_cnt;
    end
  end

  // Published results and handshake; a new publish always wins over an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      res.x_min <= 11'd0; res.x_max <= 11'd0;
      res.y_min <= 11'd0; res.y_max <= 11'd0;
      res.pix_cnt <= 20'd0; res.found <= 1'b0;
      res.result_valid <= 1'b0; res.result_ovf <= 1'b0;
    end else if (state == ST_PUBLISH) begin
      res.found   <= (acc_cnt != 20'd0);
      res.pix_cnt <= acc_cnt;
      res.x_min   <= (acc_cnt != 20'd0) ? acc_xmin : 11'd0;
      res.x_max   <= (acc_cnt != 20'd0) ? acc_xmax : 11'd0;
      res.y_min   <= (acc_cnt != 20'd0) ? acc_ymin : 11'd0;
      res.y_max   <= (acc_cnt != 20'd0) ? acc_ymax : 11'd0;
      res.result_valid <= 1'b1;
      res.result_ovf   <= res.result_valid && !res.result_ack;
    end else if (res.result_valid && res.result_ack) begin
      res.result_valid <= 1'b0;
      res.result_ovf   <= 1'b0;
    end
  end

endmodule

// File: doc/hsv_bbox_detect.md
HSV_BBOX_DETECT -- requirements
Module: hsv_bbox_detect

Interface
REQ-001 SHALL have parameter H_MIN, default 8'd21, lower hue bound (8-bit scaled hue).
REQ-002 SHALL have parameter H_MAX, default 8'd32, upper hue bound.
REQ-003 SHALL have parameter S_MIN, default 8'd40, minimum saturation.
REQ-004 SHALL have parameter V_MIN, default 8'd50, minimum value.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports hsv_vsync / hsv_hsync / hsv_de  input  1 each  upstream timing; vsync active-high.
REQ-008 SHALL have port hsv_data  input  24  {V[23:16], S[15:8], H[7:0]}, hue scaled 0..255.
REQ-009 SHALL have ports mask_vsync / mask_hsync / mask_de  output  1 each  timing delayed to match mask_data.
REQ-010 SHALL have port mask_data  output  24  24'hFFFFFF on match, 24'h000000 otherwise.
REQ-011 SHALL have ports x_min, x_max  output  11 each and y_min, y_max  output  11 each  bounding box of matches.
REQ-012 SHALL have port pix_cnt  output  20  matching pixel count of the published frame.
REQ-013 SHALL have port found  output  1  published frame had at least one match.
REQ-014 SHALL have ports result_valid  output  1, result_ack  input  1, result_ovf  output  1  result handshake.

Function
REQ-015 SHALL classify a pixel as match when S>=S_MIN, V>=V_MIN and hue in range: H_MIN<=H<=H_MAX if H_MIN<=H_MAX, else H>=H_MIN or H<=H_MAX (wrap-around).
REQ-016 SHALL produce mask_data and delayed timing with exactly 2 cycles latency; mask_data SHALL be 0 when delayed de is low.
REQ-017 SHALL maintain x counter: 0 on first de-high pixel of a line, +1 per de-high cycle, saturating at 2047.
REQ-018 SHALL maintain y counter: +1 on each de falling edge, saturating at 2047, cleared to 0 on vsync rising edge.
REQ-019 SHALL run FSM WAIT_FRAME -> ACCUM on first vsync rising edge after reset; ACCUM -> PUBLISH on next vsync rising edge; PUBLISH -> ACCUM after exactly one cycle.
REQ-020 SHALL in WAIT_FRAME ignore pixels and never publish (first partial frame discarded).
REQ-021 SHALL in ACCUM update running min/max of x and y and increment count (saturating at 2^20-1) for each de-high match.
REQ-022 SHALL in PUBLISH copy accumulators to outputs, set found=(count!=0), set result_valid=1, and clear accumulators (min to 2047, max to 0, count to 0) the same cycle.
REQ-023 SHALL output x_min=x_max=y_min=y_max=0 when found=0.
REQ-024 SHALL hold all result outputs stable while result_valid=1 until a publish replaces them.
REQ-025 SHALL clear result_valid and result_ovf the cycle after result_ack sampled high while result_valid=1; ack with result_valid=0 has no effect.
REQ-026 SHALL, if PUBLISH occurs while result_valid=1 and not acked that cycle, overwrite results and set result_ovf=1 (sticky until ack).
REQ-027 SHALL treat PUBLISH coinciding with result_ack as new publish winning: result_valid stays 1, result_ovf=0.
REQ-028 SHALL let a match on the same cycle as vsync rising edge count toward the new frame, not the published one.

Reset
REQ-029 SHALL on rst=1 drive all outputs to 0, counters and accumulators cleared (min to 2047), FSM to WAIT_FRAME, pipeline flushed.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame and require a fresh vsync rising edge before accumulating.

Verification
REQ-031 SHALL test 8x4 frame, matching pixel (H=25,S=100,V=100) at x=3..5, y=1..2 -> publish x_min=3,x_max=5,y_min=1,y_max=2,pix_cnt=6,found=1.
REQ-032 SHALL test H_MIN=240,H_MAX=10; pixels H=250 and H=5 match, H=128 does not -> mask_data FFFFFF,FFFFFF,000000, 2 cycles after input.
REQ-033 SHALL test frame with no matches -> found=0, all bbox fields 0, pix_cnt=0, result_valid=1.
REQ-034 SHALL test two frames published without result_ack -> second frame's values shown, result_ovf=1; ack -> result_valid=0, result_ovf=0 next cycle.
REQ-035 SHALL test first frame after reset fully matching -> no publish until the second vsync rising edge.
REQ-036 SHALL test rst pulse mid-frame -> all outputs 0 next cycle, next complete frame published correctly.
